// File: rtl/led_shift_serializer.sv
// rtl/led_shift_serializer.sv - MSB-first LED word serializer with divided shift clock and latch strobe.
// Optional automatic re-send of the held word after an idle period: define LED_REFRESH_EN.

module led_shift_serializer #(
   parameter int WIDTH       = 24,
   parameter int HALF_PER    = 1,
   parameter int REFRESH_CYC = 1000000
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] DATA_IN,
   input  logic             EN_IN,
   output logic             RDY,
   output logic             LED_CLK,
   output logic             LED_OE,
   output logic             LED_OUT
);

   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int PW = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shadow, shadow_nxt;
   logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
   logic [PW-1:0]    phase_cnt, phase_nxt;
   logic             half, half_nxt;
   logic             rdy_nxt, led_clk_nxt, led_oe_nxt, led_out_nxt;
   logic             phase_end;
   logic             refresh_hit;

   assign phase_end = (phase_cnt == PW'(HALF_PER - 1));

`ifdef LED_REFRESH_EN
   localparam int RW = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
   logic [RW-1:0] idle_cnt, idle_cnt_nxt;

   assign refresh_hit = (idle_cnt == RW'(REFRESH_CYC - 1));
`else
   assign refresh_hit = 1'b0;
`endif

   always_comb begin
      state_nxt   = state;
      shadow_nxt  = shadow;
      bit_cnt_nxt = bit_cnt;
      phase_nxt   = phase_cnt;
      half_nxt    = half;
      rdy_nxt     = RDY;
      led_clk_nxt = LED_CLK;
      led_oe_nxt  = LED_OE;
      led_out_nxt = LED_OUT;
`ifdef LED_REFRESH_EN
      idle_cnt_nxt = idle_cnt;
`endif

      unique case (state)
         IDLE: begin
            rdy_nxt     = 1'b1;
            led_clk_nxt = 1'b0;
            led_oe_nxt  = 1'b0;
            // RDY is still low on the first cycle out of reset, so nothing starts then.
            if (RDY && (EN_IN || refresh_hit)) begin
               if (EN_IN) begin
                  shadow_nxt = DATA_IN;
               end
               led_out_nxt = EN_IN ? DATA_IN[WIDTH-1] : shadow[WIDTH-1];
               bit_cnt_nxt = BW'(WIDTH - 1);
               phase_nxt   = '0;
               half_nxt    = 1'b0;
               rdy_nxt     = 1'b0;
               state_nxt   = SHIFT;
`ifdef LED_REFRESH_EN
               idle_cnt_nxt = '0;
            end else begin
               idle_cnt_nxt = idle_cnt + RW'(1);
`endif
            end
         end

         SHIFT: begin
            phase_nxt = phase_end ? '0 : phase_cnt + PW'(1);
            if (phase_end) begin
               if (!half) begin
                  half_nxt    = 1'b1;
                  led_clk_nxt = 1'b1;
               end else begin
                  // Data only moves on the falling shift clock, giving a full half-period of setup and hold.
                  half_nxt    = 1'b0;
                  led_clk_nxt = 1'b0;
                  if (bit_cnt == '0) begin
                     led_oe_nxt = 1'b1;
                     state_nxt  = LATCH;
                  end else begin
                     bit_cnt_nxt = bit_cnt - BW'(1);
                     led_out_nxt = shadow[bit_cnt_nxt];
                  end
               end
            end
         end

         LATCH: begin
            phase_nxt = phase_end ? '0 : phase_cnt + PW'(1);
            if (phase_end) begin
               if (!half) begin
                  half_nxt = 1'b1;
               end else begin
                  half_nxt   = 1'b0;
                  led_oe_nxt = 1'b0;
                  rdy_nxt    = 1'b1;
                  state_nxt  = IDLE;
               end
            end
         end

         default: begin
            state_nxt   = IDLE;
            led_clk_nxt = 1'b0;
            led_oe_nxt  = 1'b0;
            rdy_nxt     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state     <= IDLE;
         shadow    <= '0;
         bit_cnt   <= '0;
         phase_cnt <= '0;
         half      <= 1'b0;
         RDY       <= 1'b0;
         LED_CLK   <= 1'b0;
         LED_OE    <= 1'b0;
         LED_OUT   <= 1'b0;
`ifdef LED_REFRESH_EN
         idle_cnt  <= '0;
`endif
      end else begin
         state     <= state_nxt;
         shadow    <= shadow_nxt;
         bit_cnt   <= bit_cnt_nxt;
         phase_cnt <= phase_nxt;
         half      <= half_nxt;
         RDY       <= rdy_nxt;
         LED_CLK   <= led_clk_nxt;
         LED_OE    <= led_oe_nxt;
         LED_OUT   <= led_out_nxt;
`ifdef LED_REFRESH_EN
         idle_cnt  <= idle_cnt_nxt;
`endif
      end
   end

endmodule
